mem_port_arbiter: RTL and testbench

Shares the single external memory port of the MIPS-C core between the instruction-fetch requester (I) and the load/store requester (D).
- Grants one requester at a time and holds the grant until the memory answers or a timeout fires.
- Drives `mem_sel`, which steers the address/write-data Mux2to1 in the memory stage.
- Returns read data, `ack` and `err` to the granted requester.
- Sits between the pipeline front/back ends and the memory bus.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/arb_timeout_cnt.sv | 31 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS-C memory-port arbiter: state encoding,
// mux-select polarity and the full-word byte-enable pattern.
package mips_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  localparam logic SEL_IFETCH = 1'b0;
  localparam logic SEL_DATA   = 1'b1;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Saturating increment used by the fetch-starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// 8-bit cycle counter with synchronous clear and enable; tc flags the last
// cycle (count == LIMIT-1) before an access must be abandoned.
module arb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch (I) and
// load/store (D). mem_sel steers the memory-stage address/data Mux2to1.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_sel
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       busy;
  logic       turnaround;
  logic       grant_d;
  logic       grant_i;
  logic       to_tc;
  logic       finish;

  assign busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);

  // The cycle an ack is out is a dead arbitration cycle: the requester is
  // dropping its req, and letting D re-request here is what allows the
  // starvation limit to be reached at all.
  assign turnaround = if_ack || d_ack;

  assign grant_d = (state == ST_IDLE) && !turnaround && d_req &&
                   (!if_req || (starve_cnt != STARVE_LIM));
  assign grant_i = (state == ST_IDLE) && !turnaround && if_req && !grant_d;

  // mem_ready takes priority over a coinciding timeout.
  assign finish = busy && (mem_ready || to_tc);

  arb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_i || grant_d),
    .en    (busy && !mem_ready),
    .tc    (to_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_sel    <= SEL_IFETCH;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;

      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_BUSY_D;
            mem_req   <= 1'b1;
            mem_sel   <= SEL_DATA;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req) begin
              starve_cnt <= sat_inc4(starve_cnt, STARVE_LIM);
            end
          end else if (grant_i) begin
            state      <= ST_BUSY_I;
            mem_req    <= 1'b1;
            mem_sel    <= SEL_IFETCH;
            mem_we     <= 1'b0;
            mem_be     <= BE_WORD;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end

        ST_BUSY_I: begin
          if (finish) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_err   <= !mem_ready;
            if_rdata <= mem_ready ? mem_rdata : '0;
          end
        end

        ST_BUSY_D: begin
          if (finish) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= !mem_ready;
            d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_sel;

  int checks = 0;
  int errors = 0;

  // Memory responder mode: 0 ready on every request, 1 never ready,
  // 2 random (also while idle), 3 driven from force_ready/force_rdata.
  int            mem_mode = 0;
  logic          force_ready = 1'b0;
  logic [DW-1:0] force_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_sel   (mem_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 fetch, 2 data; age = which busy cycle is in progress.
  int            m_owner;
  int            m_age;
  int            m_starve;
  logic          e_mem_req, e_mem_sel, e_mem_we;
  logic [3:0]    e_mem_be;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic          e_if_ack, e_if_err, e_d_ack, e_d_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_age <= 0; m_starve <= 0;
      e_mem_req <= 0; e_mem_sel <= 0; e_mem_we <= 0; e_mem_be <= 0;
      e_mem_addr <= 0; e_mem_wdata <= 0;
      e_if_ack <= 0; e_if_err <= 0; e_if_rdata <= 0;
      e_d_ack <= 0; e_d_err <= 0; e_d_rdata <= 0;
    end else begin
      e_if_ack <= 0; e_if_err <= 0; e_if_rdata <= 0;
      e_d_ack <= 0; e_d_err <= 0; e_d_rdata <= 0;
      if (m_owner == 0) begin
        if (!(e_if_ack || e_d_ack)) begin
          if (d_req && (!if_req || m_starve < STARVE_MAX)) begin
            m_owner <= 2; m_age <= 1; e_mem_req <= 1; e_mem_sel <= 1;
            e_mem_we <= d_we; e_mem_be <= d_be; e_mem_addr <= d_addr; e_mem_wdata <= d_wdata;
            if (if_req) m_starve <= (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
          end else if (if_req) begin
            m_owner <= 1; m_age <= 1; e_mem_req <= 1; e_mem_sel <= 0;
            e_mem_we <= 0; e_mem_be <= 4'hF; e_mem_addr <= if_addr; e_mem_wdata <= 0;
            m_starve <= 0;
          end
        end
      end else if (mem_ready || m_age == TIMEOUT) begin
        if (m_owner == 1) begin
          e_if_ack <= 1; e_if_err <= !mem_ready;
          e_if_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          e_d_ack <= 1; e_d_err <= !mem_ready;
          e_d_rdata <= (mem_ready && !e_mem_we) ? mem_rdata : '0;
        end
        e_mem_req <= 0;
        m_owner <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mem_req", mem_req, e_mem_req);
    check("mem_sel", mem_sel, e_mem_sel);
    if (e_mem_req) begin
      check("mem_addr", mem_addr, e_mem_addr);
      check("mem_we", mem_we, e_mem_we);
      check("mem_be", mem_be, e_mem_be);
      check("mem_wdata", mem_wdata, e_mem_wdata);
    end
    check("if_ack", if_ack, e_if_ack);
    check("d_ack", d_ack, e_d_ack);
    if (e_if_ack) begin
      check("if_err", if_err, e_if_err);
      check("if_rdata", if_rdata, e_if_rdata);
    end
    if (e_d_ack) begin
      check("d_err", d_err, e_d_err);
      check("d_rdata", d_rdata, e_d_rdata);
    end
    check("acks_exclusive", if_ack && d_ack, 1'b0);
  end

  // ---------------- memory responder ----------------
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      case (mem_mode)
        0: begin mem_ready = mem_req; mem_rdata = $urandom; end
        1: begin mem_ready = 1'b0;    mem_rdata = $urandom; end
        2: begin mem_ready = ($urandom_range(0, 2) == 0); mem_rdata = $urandom; end
        default: begin mem_ready = force_ready; mem_rdata = force_rdata; end
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Runs D back-to-back against a held fetch until the fetch is acked;
  // returns the number of D grants seen before the fetch grant.
  task automatic run_starve(output int n_d);
    bit got_i = 0;
    bit done  = 0;
    n_d = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #1;
      if (mem_req && !got_i) begin
        if (mem_sel) n_d++;
        else got_i = 1;
      end
      if (if_ack) begin if_req = 0; done = 1; end
      else if_req = 1;
      d_req = !d_ack;
    end
    check("starve_fetch_acked", done, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin : main
    int n;
    int busy;
    bit got;

    rst_n = 1'b1;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_sel", mem_sel, 1'b0);
    check("rst_acks", {if_ack, d_ack, if_err, d_err}, 4'h0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Single fetch: ack two cycles after the sampled request.
    mem_mode = 3; force_ready = 0; force_rdata = 32'h2408_0005;
    if_req = 1; if_addr = 32'h0040_0000;
    @(negedge clk); #1;
    check("fetch_mem_req", mem_req, 1'b1);
    check("fetch_mem_sel", mem_sel, 1'b0);
    check("fetch_mem_we", mem_we, 1'b0);
    check("fetch_mem_be", mem_be, 4'hF);
    check("fetch_mem_addr", mem_addr, 32'h0040_0000);
    force_ready = 1;
    @(negedge clk); #1;
    check("fetch_ack", if_ack, 1'b1);
    check("fetch_err", if_err, 1'b0);
    check("fetch_rdata", if_rdata, 32'h2408_0005);
    check("fetch_req_dropped", mem_req, 1'b0);
    if_req = 0; force_ready = 0;
    idle(2);

    // Simultaneous requests: store wins, fetch follows after d_ack.
    mem_mode = 0;
    if_req = 1; if_addr = 32'h0040_0004;
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h1000_0010; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    check("sim_mem_sel", mem_sel, 1'b1);
    check("sim_mem_we", mem_we, 1'b1);
    check("sim_mem_be", mem_be, 4'h3);
    check("sim_mem_addr", mem_addr, 32'h1000_0010);
    check("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("sim_d_ack", d_ack, 1'b1);
    check("sim_d_rdata_store", d_rdata, 32'h0);
    d_req = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk); #1;
      if (mem_req && !mem_sel) got = 1;
    end
    check("sim_fetch_granted", got, 1'b1);
    @(negedge clk); #1;
    check("sim_fetch_ack", if_ack, 1'b1);
    if_req = 0;
    idle(2);

    // Starvation: exactly STARVE_MAX D grants before the fetch, twice.
    d_we = 0; d_be = 4'hF; d_addr = 32'h1000_0100;
    if_req = 1; d_req = 1;
    run_starve(n);
    check("starve_d_grants_1", n, 4);
    run_starve(n);
    check("starve_d_grants_2", n, 4);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); #1;
      if (d_ack) begin d_req = 0; got = 1; end
    end
    check("starve_d_drained", got, 1'b1);
    idle(2);

    // Timeout: memory never answers.
    mem_mode = 1;
    d_req = 1; d_we = 0; d_addr = 32'h2000_0000;
    n = 0; got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk); #1;
      if (d_ack) got = 1;
      else if (mem_req) n++;
    end
    check("to_ack_seen", got, 1'b1);
    check("to_busy_cycles", n, TIMEOUT);
    check("to_err", d_err, 1'b1);
    check("to_rdata", d_rdata, 32'h0);
    d_req = 0;
    idle(2);

    // Timeout collision: ready arrives in the last allowed busy cycle.
    mem_mode = 3; force_ready = 0; force_rdata = 32'h1234_5678;
    d_req = 1; d_we = 0; d_addr = 32'h2000_0004;
    busy = 0; got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk); #1;
      if (d_ack) got = 1;
      else if (mem_req) begin
        busy++;
        if (busy == TIMEOUT) force_ready = 1;
      end
    end
    check("col_ack_seen", got, 1'b1);
    check("col_err", d_err, 1'b0);
    check("col_rdata", d_rdata, 32'h1234_5678);
    d_req = 0; force_ready = 0;
    idle(2);

    // Reset mid-access: mem_req drops at once, no ack afterwards.
    mem_mode = 1;
    d_req = 1; d_we = 1; d_addr = 32'h3000_0000; d_wdata = 32'hCAFE_F00D;
    idle(2);
    check("rma_busy", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rma_req_async", mem_req, 1'b0);
    check("rma_no_ack", d_ack, 1'b0);
    d_req = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rma_idle_req", mem_req, 1'b0);
      check("rma_idle_ack", d_ack, 1'b0);
      check("rma_idle_sel", mem_sel, 1'b0);
    end

    // Randomized traffic with reactive requesters.
    mem_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (if_ack) if_req = 0;
      else if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = $urandom;
      end
      if (d_ack) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
